mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial scheduler sharing a single-port byte RAM between fetch and load/store.
// Optional macro FETCH_ABORT_EN: if_cancel blocks/aborts fetches.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  input  logic                      if_cancel,
  output logic                      if_done,
  output logic [31:0]               if_data,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [1:0]                mem_len,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [31:0]               mem_wdata,
  output logic                      mem_done,
  output logic [31:0]               mem_rdata,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic                      ram_wr,
  output logic [7:0]                ram_dout,
  input  logic [7:0]                ram_din
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic [RAM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      sel_if_q, sel_if_d;
  logic [DATA_W-1:0]         asm_q, asm_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic                      ram_wr_q, ram_wr_d;
  logic [7:0]                ram_dout_q, ram_dout_d;
  logic                      if_done_q, if_done_d;
  logic                      mem_done_q, mem_done_d;
  logic [DATA_W-1:0]         if_data_q, if_data_d;
  logic [DATA_W-1:0]         mem_rdata_q, mem_rdata_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       cap_idx;
  logic             fetch_block;
  logic             fetch_abort;
  logic             unused_bits;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign cap_idx = 2'(cnt_q - CNT_W'(1));

`ifdef FETCH_ABORT_EN
  assign fetch_block = if_cancel;
  assign fetch_abort = if_cancel & sel_if_q;
  assign unused_bits = ^{if_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                         mem_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH]};
`else
  assign fetch_block = 1'b0;
  assign fetch_abort = 1'b0;
  assign unused_bits = ^{if_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH],
                         mem_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH], if_cancel};
`endif

  // Transaction length in bytes; encoding 3 behaves as a word.
  function automatic logic [CNT_W-1:0] len_decode(input logic [1:0] len);
    case (len)
      2'd0:    return CNT_W'(1);
      2'd1:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      sel_if_q    <= 1'b0;
      asm_q       <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      sel_if_q    <= sel_if_d;
      asm_q       <= asm_d;
      ram_a_q     <= ram_a_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state and next-output logic; RAM outputs are set one edge ahead of use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    sel_if_d    = sel_if_q;
    asm_d       = asm_q;
    ram_a_d     = ram_a_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          sel_if_d = 1'b0;
          base_d   = mem_addr[RAM_ADDR_WIDTH-1:0];
          ram_a_d  = mem_addr[RAM_ADDR_WIDTH-1:0];
          len_d    = len_decode(mem_len);
          wdata_d  = mem_wdata;
          cnt_d    = '0;
          asm_d    = '0;
          if (mem_we) begin
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
            state_d    = WRITE;
          end else begin
            state_d = READ;
          end
        end else if (if_req && !fetch_block) begin
          sel_if_d = 1'b1;
          base_d   = if_addr[RAM_ADDR_WIDTH-1:0];
          ram_a_d  = if_addr[RAM_ADDR_WIDTH-1:0];
          len_d    = CNT_W'(4);
          cnt_d    = '0;
          asm_d    = '0;
          state_d  = READ;
        end
      end

      READ: begin
        if (fetch_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          // Byte addressed last cycle is on ram_din now.
          if (cnt_q != '0) begin
            asm_d[{cap_idx, 3'b000} +: 8] = ram_din;
          end
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = DONE;
            if (sel_if_q) begin
              if_data_d = asm_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = asm_d;
              mem_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < len_q) begin
              ram_a_d = base_q + RAM_ADDR_WIDTH'(cnt_inc);
            end
          end
        end
      end

      WRITE: begin
        if (cnt_inc < len_q) begin
          cnt_d      = cnt_inc;
          ram_a_d    = base_q + RAM_ADDR_WIDTH'(cnt_inc);
          ram_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          cnt_d      = '0;
          mem_done_d = 1'b1;
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule
